// File: rtl/bcd_stopwatch_core.sv
// bcd_stopwatch_core: packed-BCD HH:MM:SS.CC up/down stopwatch with lap freeze and validated load
module bcd_stopwatch_core #(
  parameter int TICK_DIV = 500_000,
  parameter int HOUR_MOD = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clr,
  input  logic        dir,
  input  logic        lap,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  output logic        load_ready,
  output logic        load_err,
  output logic [31:0] bcd_out,
  output logic        tick,
  output logic        wrap,
  output logic        expired,
  output logic        running,
  output logic        frozen
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [7:0] H_MAX = 8'(((HOUR_MOD - 1) / 10) * 16 + (HOUR_MOD - 1) % 10);
  typedef enum logic [1:0] {STOPPED, RUNNING, EXPIRED} state_t;
  state_t state;
  logic [PW-1:0] presc;
  logic [31:0] cnt, snap, nxt;
  logic [8:0] c, s, m, h;
  logic tick_now, ld, ld_ok;
  // {carry/borrow, pair}: one BCD step of a two-digit field whose top value is mx
  function automatic logic [8:0] step2(input logic [7:0] v, input logic [7:0] mx, input logic dn, input logic en);
    if (!en) return {1'b0, v};
    if (dn) return v == 8'h00 ? {1'b1, mx} : v[3:0] == 4'd0 ? {1'b0, v[7:4] - 4'd1, 4'd9} : {1'b0, v[7:4], v[3:0] - 4'd1};
    return v == mx ? 9'h100 : v[3:0] == 4'd9 ? {1'b0, v[7:4] + 4'd1, 4'd0} : {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction
  always_comb begin
    c = step2(cnt[7:0], 8'h99, dir, 1'b1);
    s = step2(cnt[15:8], 8'h59, dir, c[8]);
    m = step2(cnt[23:16], 8'h59, dir, s[8]);
    h = step2(cnt[31:24], H_MAX, dir, m[8]);
  end
  // digits are checked <=9 first, so a plain compare on the hour byte is a numeric compare
  always_comb begin
    ld_ok = load_data[31:24] <= H_MAX && load_data[23:20] <= 4'd5 && load_data[15:12] <= 4'd5;
    for (int i = 0; i < 8; i++) ld_ok = ld_ok && load_data[4*i +: 4] <= 4'd9;
  end
  assign nxt        = {h[7:0], m[7:0], s[7:0], c[7:0]};
  assign load_ready = state != RUNNING;
  assign running    = state == RUNNING;
  assign expired    = state == EXPIRED;
  assign bcd_out    = frozen ? snap : cnt;
  assign ld         = load_valid && load_ready && !clr;
  assign tick_now   = state == RUNNING && !clr && !stop && presc == PW'(TICK_DIV - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= STOPPED;
      presc    <= '0;
      cnt      <= '0;
      snap     <= '0;
      frozen   <= 1'b0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tick     <= tick_now;
      wrap     <= tick_now && !dir && h[8];
      load_err <= ld && !ld_ok;
      if (clr) begin
        state  <= STOPPED;
        presc  <= '0;
        cnt    <= '0;
        frozen <= 1'b0;
      end else begin
        if (lap) begin
          frozen <= !frozen;
          if (!frozen) snap <= tick_now ? nxt : cnt;
        end
        if (ld) begin
          if (ld_ok) begin
            cnt   <= load_data;
            presc <= '0;
            if (state == EXPIRED) state <= STOPPED;
          end
        end else if (state == RUNNING) begin
          if (stop) state <= STOPPED;
          else if (tick_now) begin
            presc <= '0;
            cnt   <= nxt;
            if (dir && nxt == '0) state <= EXPIRED;
          end else presc <= presc + PW'(1);
        end else if (start && !stop) begin
          if (state == STOPPED) state <= (dir && cnt == '0) ? EXPIRED : RUNNING;
          else if (cnt != '0) state <= RUNNING;
        end
      end
    end
  end
endmodule
